// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, default address/data widths, NOP encoding.
package imem_responder_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    // Value presented on instr while nothing has been fetched yet.
    localparam logic [7:0] NOP = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2
    } state_t;

endpackage

// File: rtl/imem_responder_array.sv
// imem_array: 2**AW x DW synchronous RAM, one write port, one read port, read-first.
// Latency: one cycle from raddr/re to rdata; rdata holds whenever re is low.
// Backpressure: none; the caller gates re to freeze the read register.
// Ports: clk, rst (async, active-high, clears only the read register),
//        we/waddr/wdata write port, re/raddr read port, rdata read data,
//        rerr stored-parity mismatch on the word in rdata (IMEM_PARITY_EN only).
// Build option: IMEM_PARITY_EN adds one even-parity bit per word.
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
`ifdef IMEM_PARITY_EN
    ,
    output logic          rerr
`endif
);

`ifdef IMEM_PARITY_EN
    // Bit DW holds the even-parity bit so that the full stored word has an even
    // number of ones.
    logic [DW:0] mem [2**AW];
    logic        rpar;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= {^wdata, wdata};
        end
    end

    // Non-blocking read of the pre-edge contents gives read-first behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= DW'(NOP);
            rpar  <= 1'b0;
        end else if (re) begin
            {rpar, rdata} <= mem[raddr];
        end
    end

    assign rerr = ^{rpar, rdata};
`else
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking read of the pre-edge contents gives read-first behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= DW'(NOP);
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder at the end of the pc address bus.
// Latency: one cycle; addr sampled at an edge appears on instr/instr_addr after it.
// Backpressure: stall freezes instr/instr_addr/instr_valid and suppresses the read.
// Ports: clk, reset (async, active-high); addr fetch address; branch squashes the
//        in-flight fetch; stall holds outputs; prog_we/prog_addr/prog_data program
//        load port; instr/instr_addr/instr_valid fetch result; parity_err when
//        built with IMEM_PARITY_EN (stored-parity mismatch on the word in instr).
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic          branch,
    input  logic          stall,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_addr,
    output logic          instr_valid
`ifdef IMEM_PARITY_EN
    ,
    output logic          parity_err
`endif
);

    state_t state;
    logic   vld_q;
    logic   fetch;

    // Read enable for the array. In IDLE a load blocks the fetch. In RUN and
    // SQUASH a load or a branch still captures the word (flagged invalid), and
    // only a plain stall suppresses the read. SQUASH carries no valid word, so
    // it always refetches regardless of stall.
    always_comb begin
        fetch = 1'b0;
        case (state)
            IDLE:    fetch = !prog_we;
            RUN:     fetch = prog_we || branch || !stall;
            SQUASH:  fetch = 1'b1;
            default: fetch = 1'b0;
        endcase
    end

    imem_array #(
        .AW(AW),
        .DW(DW)
    ) u_array (
        .clk   (clk),
        .rst   (reset),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (fetch),
        .raddr (addr),
        .rdata (instr)
`ifdef IMEM_PARITY_EN
        ,
        .rerr  (parity_err)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            instr_addr <= '0;
            vld_q      <= 1'b0;
        end else begin
            if (fetch) begin
                instr_addr <= addr;
            end
            case (state)
                IDLE: begin
                    if (!prog_we) begin
                        state <= RUN;
                        vld_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (prog_we) begin
                        state <= IDLE;
                        vld_q <= 1'b0;
                    end else if (branch) begin
                        state <= SQUASH;
                        vld_q <= 1'b0;
                    end else if (!stall) begin
                        vld_q <= 1'b1;
                    end
                end
                SQUASH: begin
                    if (prog_we) begin
                        state <= IDLE;
                        vld_q <= 1'b0;
                    end else if (branch) begin
                        state <= SQUASH;
                        vld_q <= 1'b0;
                    end else begin
                        state <= RUN;
                        vld_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

    // A corrupted word is never handed to decode; the FSM does not react to it.
`ifdef IMEM_PARITY_EN
    assign instr_valid = vld_q && !parity_err;
`else
    assign instr_valid = vld_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model. IMEM_PARITY_EN adds a parity-corruption scenario.
module tb_imem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr;
    logic       branch;
    logic       stall;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] instr;
    logic [7:0] instr_addr;
    logic       instr_valid;
`ifdef IMEM_PARITY_EN
    logic       parity_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imem_responder #(.AW(8), .DW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .branch      (branch),
        .stall       (stall),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instr       (instr),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid)
`ifdef IMEM_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The responder is either "parked" (after reset or a load) or "streaming";
    // a streaming responder owes one invalid cycle after each branch and must
    // refetch immediately after it.
    logic [7:0] m_mem [256];
    bit         m_bad [256];
    bit         m_parked;
    bit         m_owe_refetch;
    bit         m_take;
    logic [7:0] e_instr;
    logic [7:0] e_addr;
    bit         e_vld;
    bit         e_perr;

    initial begin
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = 8'h00;
            m_bad[i] = 1'b0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_instr       = 8'h00;
            e_addr        = 8'h00;
            e_vld         = 1'b0;
            e_perr        = 1'b0;
            m_parked      = 1'b1;
            m_owe_refetch = 1'b0;
        end else begin
            m_take = 1'b0;
            if (m_parked) begin
                if (!prog_we) begin
                    m_take = 1'b1; e_vld = 1'b1; m_parked = 1'b0; m_owe_refetch = 1'b0;
                end
            end else if (prog_we) begin
                m_take = 1'b1; e_vld = 1'b0; m_parked = 1'b1; m_owe_refetch = 1'b0;
            end else if (branch) begin
                m_take = 1'b1; e_vld = 1'b0; m_owe_refetch = 1'b1;
            end else if (m_owe_refetch || !stall) begin
                m_take = 1'b1; e_vld = 1'b1; m_owe_refetch = 1'b0;
            end
            // Read happens before the write of the same edge (old data wins).
            if (m_take) begin
                e_instr = m_mem[addr];
                e_addr  = addr;
                e_perr  = m_bad[addr];
            end
            if (prog_we) begin
                m_mem[prog_addr] = prog_data;
                m_bad[prog_addr] = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("instr", 32'(instr), 32'(e_instr));
        check("instr_addr", 32'(instr_addr), 32'(e_addr));
        check("instr_valid", 32'(instr_valid), 32'(e_vld && !e_perr));
`ifdef IMEM_PARITY_EN
        check("parity_err", 32'(parity_err), 32'(e_perr));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit we, input logic [7:0] wa, input logic [7:0] wd,
                        input logic [7:0] a, input bit br, input bit st);
        prog_we   = we;
        prog_addr = wa;
        prog_data = wd;
        addr      = a;
        branch    = br;
        stall     = st;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string nm, input logic [7:0] ei, input logic [7:0] ea, input bit ev);
        check({nm, ".instr"}, 32'(instr), 32'(ei));
        check({nm, ".addr"}, 32'(instr_addr), 32'(ea));
        check({nm, ".valid"}, 32'(instr_valid), 32'(ev));
    endtask

    logic [7:0] t1 [4];

    initial begin
        t1 = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset = 1'b1; addr = 8'h00; branch = 1'b0; stall = 1'b0;
        prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
        repeat (2) @(negedge clk);
        expect_out("reset", 8'h00, 8'h00, 1'b0);

        // Preload everything with random words, then the directed locations.
        reset = 1'b0;
        for (int i = 0; i < 256; i++) tick(1'b1, 8'(i), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
        tick(1'b1, 8'hAA, 8'h5A, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 8'h05, 8'h55, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 8'hFF, 8'hEE, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(i), t1[i], 8'h00, 1'b0, 1'b0);
        expect_out("load_idle", 8'h00, 8'h00, 1'b0);

        // 1: sequential fetch after load
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 8'h00, 8'h00, 8'(i), 1'b0, 1'b0);
            expect_out("seq", t1[i], 8'(i), 1'b1);
        end

        // 2: branch squash
        tick(1'b0, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0);
        expect_out("squash", 8'h33, 8'h02, 1'b0);
        tick(1'b0, 8'h00, 8'h00, 8'hAA, 1'b0, 1'b0);
        expect_out("target", 8'h5A, 8'hAA, 1'b1);

        // 3: stall hold, then resume at the current address
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 8'h00, 8'h00, 8'(8'hB0 + k), 1'b0, 1'b1);
            expect_out("stall", 8'h5A, 8'hAA, 1'b1);
        end
        tick(1'b0, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
        expect_out("resume", 8'h55, 8'h05, 1'b1);

        // 4: wrap, read-first on a colliding load, then the new word
        tick(1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
        expect_out("wrap_ff", 8'hEE, 8'hFF, 1'b1);
        tick(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_out("wrap_00", 8'h11, 8'h00, 1'b1);
        tick(1'b1, 8'h05, 8'h77, 8'h05, 1'b0, 1'b0);
        expect_out("rd_first", 8'h55, 8'h05, 1'b0);
        tick(1'b0, 8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
        expect_out("new_word", 8'h77, 8'h05, 1'b1);

        // 5: asynchronous reset between edges
        tick(1'b0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0);
        expect_out("pre_rst", 8'h22, 8'h01, 1'b1);
        #2 reset = 1'b1;
        #1 expect_out("async_rst", 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 1'b0);
        expect_out("retained", 8'h33, 8'h02, 1'b1);

        // Randomized traffic, checked by the per-cycle compare.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] a;
            logic [7:0] wa;
            a  = 8'($urandom);
            wa = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end else begin
                tick($urandom_range(0, 9) == 0, wa, 8'($urandom), a,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
            end
        end

`ifdef IMEM_PARITY_EN
        // 6: corrupted stored parity at addr 3, clean word at addr 4
        tick(1'b1, 8'h03, 8'h3C, 8'h00, 1'b0, 1'b0);
        tick(1'b1, 8'h04, 8'h4D, 8'h00, 1'b0, 1'b0);
        dut.u_array.mem[3] = dut.u_array.mem[3] ^ 9'h100;
        m_bad[3] = 1'b1;
        tick(1'b0, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0);
        check("perr_bad", 32'(parity_err), 32'd1);
        expect_out("perr_bad", 8'h3C, 8'h03, 1'b0);
        tick(1'b0, 8'h00, 8'h00, 8'h04, 1'b0, 1'b0);
        check("perr_clean", 32'(parity_err), 32'd0);
        expect_out("perr_clean", 8'h4D, 8'h04, 1'b1);
`endif

        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
